tone_decoder: RTL and testbench

- Receive-side counterpart of the sound controller. Watches the audio/gain/notshutdown lines and measures the square-wave half-period in clk cycles.
- Classifies each tone burst as a round-win tone (high pitch) or a game-win tone (low pitch), then emits a one-cycle detect pulse when the burst ends.
- Used as an on-chip self-test/loopback monitor and as the checker in sound-path benches. Burst duration is timed with the shared slowen tick from the clock divider.

---
 rtl/tone_decoder.sv | 173 +++++++++++++++++
 tb/tb_tone_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - tone burst classifier with end-of-burst detect pulses; GAIN_CHECK_EN enables the sticky err flag
module tone_decoder #(
    parameter int CNT_W     = 12,
    parameter int HI_MIN    = 40,
    parameter int HI_MAX    = 60,
    parameter int LO_MIN    = 90,
    parameter int LO_MAX    = 110,
    parameter int CONFIRM   = 4,
    parameter int TIMEOUT   = 255,
    parameter int MIN_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slowen,
    input  logic             audio,
    input  logic             gain,
    input  logic             notshutdown,
    output logic             tone_valid,
    output logic             tone_class,
    output logic [CNT_W-1:0] half_period,
    output logic             rnd_det,
    output logic             game_det,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HI_MIN_C = CNT_W'(HI_MIN);
    localparam logic [CNT_W-1:0] HI_MAX_C = CNT_W'(HI_MAX);
    localparam logic [CNT_W-1:0] LO_MIN_C = CNT_W'(LO_MIN);
    localparam logic [CNT_W-1:0] LO_MAX_C = CNT_W'(LO_MAX);
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);
    localparam logic [7:0]       CONF_C   = 8'(CONFIRM);
    localparam logic [7:0]       MINT_C   = 8'(MIN_TICKS);

    state_t           state, next_state;
    logic             audio_q, audio_p;
    logic             edge_det;
    logic [CNT_W-1:0] cnt, c_val;
    logic             is_hi, is_lo, timeout;
    logic [7:0]       mcnt, mcnt_nx;
    logic [7:0]       ticks, tick_nx;
    logic             cls, cls_nx;
    logic             lock_entry, hp_load, burst_end, qualifies;

    // c_val counts the cycles since the previous edge, including the current one
    assign edge_det  = audio_q != audio_p;
    assign c_val     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    assign is_hi     = (c_val >= HI_MIN_C) && (c_val <= HI_MAX_C);
    assign is_lo     = (c_val >= LO_MIN_C) && (c_val <= LO_MAX_C);
    assign timeout   = !edge_det && (c_val >= TO_C);
    assign tick_nx   = (slowen && ticks != 8'hff) ? ticks + 8'd1 : ticks;
    assign qualifies = burst_end && (tick_nx >= MINT_C);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        mcnt_nx    = mcnt;
        cls_nx     = cls;
        lock_entry = 1'b0;
        hp_load    = 1'b0;
        burst_end  = 1'b0;
        case (state)
            S_IDLE: begin
                mcnt_nx = '0;
                if (notshutdown) next_state = S_ARM;
            end
            S_ARM: begin
                if (!notshutdown) begin
                    next_state = S_IDLE;
                    mcnt_nx    = '0;
                end else if (edge_det) begin
                    next_state = S_MEAS;
                    mcnt_nx    = '0;
                end else if (timeout) begin
                    mcnt_nx = '0;
                end
            end
            S_MEAS: begin
                if (!notshutdown) begin
                    next_state = S_IDLE;
                    mcnt_nx    = '0;
                end else if (edge_det) begin
                    if (!is_hi && !is_lo) begin
                        mcnt_nx = '0;
                    end else if (is_hi == cls) begin
                        mcnt_nx = mcnt + 8'd1;
                    end else begin
                        mcnt_nx = 8'd1;
                        cls_nx  = is_hi;
                    end
                    if ((is_hi || is_lo) && mcnt_nx >= CONF_C) begin
                        next_state = S_LOCK;
                        lock_entry = 1'b1;
                    end
                end else if (timeout) begin
                    next_state = S_ARM;
                    mcnt_nx    = '0;
                end
            end
            S_LOCK: begin
                mcnt_nx = '0;
                // shutdown outranks a coincident edge so the burst still gets its pulse
                if (!notshutdown) begin
                    burst_end  = 1'b1;
                    next_state = S_IDLE;
                end else if (edge_det) begin
                    if (cls ? is_hi : is_lo) hp_load = 1'b1;
                    else                     next_state = S_MEAS;
                end else if (timeout) begin
                    burst_end  = 1'b1;
                    next_state = S_ARM;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tone_valid = (state == S_LOCK);
        tone_class = (state == S_LOCK) && cls;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            audio_q     <= 1'b0;
            audio_p     <= 1'b0;
            cnt         <= '0;
            mcnt        <= '0;
            ticks       <= '0;
            cls         <= 1'b0;
            half_period <= '0;
            rnd_det     <= 1'b0;
            game_det    <= 1'b0;
        end else begin
            audio_q <= audio;
            audio_p <= audio_q;
            if (state == S_IDLE || edge_det) cnt <= '0;
            else                             cnt <= c_val;
            mcnt  <= mcnt_nx;
            cls   <= cls_nx;
            ticks <= (state == S_LOCK && next_state == S_LOCK) ? tick_nx : 8'd0;
            if (lock_entry || hp_load) half_period <= c_val;
            rnd_det  <= qualifies && cls;
            game_det <= qualifies && !cls;
        end
    end

`ifdef GAIN_CHECK_EN
    logic gain_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            gain_s <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (lock_entry) gain_s <= gain;
            if ((state == S_LOCK && gain != gain_s) || (burst_end && tick_nx < MINT_C))
                err <= 1'b1;
        end
    end
`else
    logic unused_gain;
    assign unused_gain = gain;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - directed bench for tone_decoder
module tb_tone_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        slowen;
    logic        audio;
    logic        gain;
    logic        notshutdown;
    logic        tone_valid;
    logic        tone_class;
    logic [11:0] half_period;
    logic        rnd_det;
    logic        game_det;
    logic        err;

`ifdef GAIN_CHECK_EN
    localparam logic GCE = 1'b1;
`else
    localparam logic GCE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int half   = 0;
    int ph     = 0;
    int div    = 0;
    int rnd_cnt = 0, game_cnt = 0, both_cnt = 0, tv_cnt = 0;
    int tv_base;

    tone_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .slowen      (slowen),
        .audio       (audio),
        .gain        (gain),
        .notshutdown (notshutdown),
        .tone_valid  (tone_valid),
        .tone_class  (tone_class),
        .half_period (half_period),
        .rnd_det     (rnd_det),
        .game_det    (game_det),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rnd_det) rnd_cnt++;
        if (game_det) game_cnt++;
        if (rnd_det && game_det) both_cnt++;
        if (tone_valid) tv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        div    = (div + 1) % 256;
        slowen = (div == 0);
        if (half != 0) begin
            ph++;
            if (ph == half) begin
                ph    = 0;
                audio = ~audio;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tv"},   32'(tone_valid),  0);
        chk({tag, "_cls"},  32'(tone_class),  0);
        chk({tag, "_hp"},   32'(half_period), 0);
        chk({tag, "_rnd"},  32'(rnd_det),     0);
        chk({tag, "_game"}, 32'(game_det),    0);
        chk({tag, "_err"},  32'(err),         0);
    endtask

    initial begin
        rst = 1'b0; slowen = 1'b0; audio = 1'b0; gain = 1'b0; notshutdown = 1'b0;

        half = 1;
        step(); step();
        chk_all_zero("reset");

        rst = 1'b1; half = 50; ph = 0;
        repeat (400) step();
        chk("idle_no_lock", 32'(tv_cnt), 0);
        chk("idle_no_pulse", 32'(rnd_cnt + game_cnt), 0);
        chk("idle_hp", 32'(half_period), 0);
        half = 0;
        repeat (5) step();
        notshutdown = 1'b1;
        repeat (20) step();

        ph = 0; half = 50;
        repeat (251) step();
        chk("hi_prelock", 32'(tone_valid), 0);
        step();
        chk("hi_lock_tv", 32'(tone_valid), 1);
        chk("hi_lock_cls", 32'(tone_class), 1);
        chk("hi_lock_hp", 32'(half_period), 50);
        repeat (748) step();
        half = 0;
        repeat (256) step();
        chk("hi_pre_to_tv", 32'(tone_valid), 1);
        chk("hi_pre_to_rnd", 32'(rnd_det), 0);
        step();
        chk("hi_rnd_pulse", 32'(rnd_det), 1);
        chk("hi_tv_drop", 32'(tone_valid), 0);
        chk("hi_game_quiet", 32'(game_det), 0);
        step();
        chk("hi_rnd_one_cycle", 32'(rnd_det), 0);
        chk("hi_rnd_count", 32'(rnd_cnt), 1);
        chk("hi_game_count", 32'(game_cnt), 0);

        repeat (50) step();
        ph = 0; half = 100;
        repeat (501) step();
        chk("lo_prelock", 32'(tone_valid), 0);
        step();
        chk("lo_lock_tv", 32'(tone_valid), 1);
        chk("lo_lock_cls", 32'(tone_class), 0);
        chk("lo_lock_hp", 32'(half_period), 100);
        repeat (998) step();
        chk("lo_pre_off_tv", 32'(tone_valid), 1);
        chk("lo_pre_off_game", 32'(game_det), 0);
        notshutdown = 1'b0; half = 0;
        step();
        chk("lo_game_pulse", 32'(game_det), 1);
        chk("lo_tv_drop", 32'(tone_valid), 0);
        chk("lo_rnd_quiet", 32'(rnd_det), 0);
        step();
        chk("lo_game_one_cycle", 32'(game_det), 0);
        chk("lo_game_count", 32'(game_cnt), 1);
        chk("lo_rnd_count", 32'(rnd_cnt), 1);

        repeat (10) step();
        notshutdown = 1'b1;
        tv_base = tv_cnt;
        ph = 0; half = 75;
        repeat (2000) step();
        half = 0;
        repeat (300) step();
        chk("oob_never_lock", 32'(tv_cnt - tv_base), 0);
        chk("oob_no_pulse", 32'(rnd_cnt + game_cnt), 2);

        div = 156; ph = 0; half = 50;
        repeat (252) step();
        chk("short_lock_tv", 32'(tone_valid), 1);
        chk("short_lock_cls", 32'(tone_class), 1);
        repeat (48) step();
        half = 0;
        repeat (257) step();
        chk("short_tv_drop", 32'(tone_valid), 0);
        chk("short_no_rnd", 32'(rnd_cnt), 1);
        chk("short_err", 32'(err), 32'(GCE));

        rst = 1'b0;
        step();
        chk("rst_err_clear", 32'(err), 0);
        rst = 1'b1;
        repeat (20) step();

        ph = 0; half = 50;
        repeat (350) step();
        half = 100;
        repeat (101) step();
        chk("chg_hi_locked", 32'(tone_valid), 1);
        step();
        chk("chg_exit_tv", 32'(tone_valid), 0);
        chk("chg_no_pulse", 32'(rnd_cnt + game_cnt), 2);
        repeat (399) step();
        chk("chg_prelock_lo", 32'(tone_valid), 0);
        step();
        chk("chg_lock_lo_tv", 32'(tone_valid), 1);
        chk("chg_lock_lo_cls", 32'(tone_class), 0);
        chk("chg_lock_lo_hp", 32'(half_period), 100);

        chk("gain_err_before", 32'(err), 0);
        gain = 1'b1;
        step();
        chk("gain_err_set", 32'(err), 32'(GCE));
        gain = 1'b0;
        repeat (5) step();
        chk("gain_err_sticky", 32'(err), 32'(GCE));

        rst = 1'b0;
        step();
        chk_all_zero("midrst1");
        step();
        chk_all_zero("midrst2");
        rst = 1'b1; notshutdown = 1'b0; half = 0;
        repeat (10) step();
        chk("midrst_tv", 32'(tone_valid), 0);
        chk("midrst_hp", 32'(half_period), 0);
        chk("midrst_no_pulse", 32'(rnd_cnt + game_cnt), 2);
        chk("never_both", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
